mem_stage_sram_ctrl: RTL and testbench

Parametrised memory-stage controller that turns RV32 load/store requests (funct3-encoded) into multi-beat accesses on an external asynchronous SRAM of configurable data width and wait states. It sits between the EX/MEM pipeline register and the board SRAM pins. It stalls the pipeline for the whole access and returns sign- or zero-extended load data with a one-cycle valid strobe. Byte order is little-endian throughout.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_load_align.sv | 22 ++
 rtl/mem_stage_sram_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: funct3 encodings, FSM states and size/beat/lane helpers shared by the memory stage
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   function automatic logic [2:0] size_bytes(input logic [2:0] f3);
      return (f3 == F3_B || f3 == F3_BU) ? 3'd1 : (f3 == F3_H || f3 == F3_HU) ? 3'd2 : 3'd4;
   endfunction

   function automatic logic [2:0] beats(input logic [2:0] f3, input int dw);
      return 3'((int'(size_bytes(f3)) + dw / 8 - 1) / (dw / 8));
   endfunction

   function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
      return (size_bytes(f3) == 3'd1) ? 4'b0001 << off : (size_bytes(f3) == 3'd2) ? 4'b0011 << off : 4'b1111;
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: picks the addressed byte/half from the assembled word and sign/zero-extends it
module mem_load_align
   import mem_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_word,
   output logic [31:0] o_data
);

   logic [15:0] w_sh;

   assign w_sh = 16'(i_word >> {i_off, 3'b000});

   // extension selected by funct3; LW passes the word through
   always_comb
      o_data = (i_funct3 == F3_B)  ? {{24{w_sh[7]}}, w_sh[7:0]}  :
               (i_funct3 == F3_BU) ? {24'h0, w_sh[7:0]}          :
               (i_funct3 == F3_H)  ? {{16{w_sh[15]}}, w_sh}      :
               (i_funct3 == F3_HU) ? {16'h0, w_sh}               : i_word;

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: RV32 load/store to multi-beat async SRAM accesses; define MEM_MISALIGN_TRAP_EN to trap misaligned accesses
module mem_stage_sram_ctrl
   import mem_pkg::*;
#(
   parameter int SRAM_DW     = 16,
   parameter int SRAM_AW     = 20,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_req_valid,
   input  logic                 i_req_write,
   input  logic [2:0]           i_req_funct3,
   input  logic [31:0]          i_req_addr,
   input  logic [31:0]          i_req_wdata,
   output logic                 o_stall,
   output logic                 o_rdata_valid,
   output logic [31:0]          o_rdata,
`ifdef MEM_MISALIGN_TRAP_EN
   output logic                 o_misaligned,
`endif
   output logic                 o_sram_ce_n,
   output logic                 o_sram_oe_n,
   output logic                 o_sram_we_n,
   output logic [SRAM_DW/8-1:0] o_sram_be_n,
   output logic [SRAM_AW-1:0]   o_sram_addr,
   output logic [SRAM_DW-1:0]   o_sram_dq_out,
   output logic                 o_sram_dq_oe,
   input  logic [SRAM_DW-1:0]   i_sram_dq_in
);

   localparam int         NB         = SRAM_DW / 8;
   localparam int         SH         = (SRAM_DW == 16) ? 1 : 0;
   localparam logic [1:0] LANE_ALIGN = ~2'(NB - 1);

   state_e              r_state;
   logic                r_write, r_null;
   logic [2:0]          r_f3, r_wc;
   logic [1:0]          r_off, r_pos, r_beat, r_last;
   logic [31:0]         r_wd, r_rd;
   logic [3:0]          r_bm;
   logic                r_ce_n, r_oe_n, r_we_n, r_dq_oe;
   logic [NB-1:0]       r_be_n;
   logic [SRAM_AW-1:0]  r_addr;
   logic [SRAM_DW-1:0]  r_dq;

   logic                w_sup, w_go;
   logic [1:0]          w_off, w_base, w_pos_nx;
   logic [31:0]         w_wd, w_rd_nx, w_ext;
   logic [3:0]          w_bm;
   logic [SRAM_AW-1:0]  w_start;
   logic [SRAM_DW-1:0]  w_dq_nx;
   logic [NB-1:0]       w_be_nx;

   assign w_sup = i_req_write ? (~i_req_funct3[2] & (i_req_funct3[1:0] != 2'b11))
                              : (i_req_funct3 != 3'b011) & (i_req_funct3[2:1] != 2'b11);

`ifdef MEM_MISALIGN_TRAP_EN
   logic r_mis, w_mis;
   assign w_mis = (size_bytes(i_req_funct3) == 3'd2) ? i_req_addr[0]
                : (size_bytes(i_req_funct3) == 3'd4) & (i_req_addr[1:0] != 2'b00);
   assign w_go  = w_sup & ~w_mis;
   assign o_misaligned = (r_state == ST_DONE) & r_mis;
`else
   assign w_go  = w_sup;
`endif

   // the address is always aligned down to the access size; trapped accesses never reach the SRAM
   assign w_off    = i_req_addr[1:0] & ~2'(size_bytes(i_req_funct3) - 3'd1);
   assign w_base   = w_off & LANE_ALIGN;
   assign w_start  = SRAM_AW'({i_req_addr[31:2], w_off} >> SH);
   assign w_wd     = i_req_wdata << {w_off, 3'b000};
   assign w_bm     = lane_mask(i_req_funct3, w_off);
   assign w_pos_nx = (r_state == ST_IDLE) ? w_base : r_pos + 2'(NB);
   assign w_dq_nx  = SRAM_DW'(((r_state == ST_IDLE) ? w_wd : r_wd) >> {w_pos_nx, 3'b000});
   assign w_be_nx  = ~NB'(((r_state == ST_IDLE) ? w_bm : r_bm) >> w_pos_nx);
   assign w_rd_nx  = r_rd | (32'(i_sram_dq_in) << {r_pos, 3'b000});

   mem_load_align u_align (
      .i_funct3 (r_f3),
      .i_off    (r_off),
      .i_word   (r_rd),
      .o_data   (w_ext)
   );

   assign o_stall       = rst_n & ((r_state == ST_IDLE & i_req_valid) | r_state == ST_ACCESS);
   assign o_rdata_valid = r_state == ST_DONE;
   assign o_rdata       = (r_state == ST_DONE & ~r_write & ~r_null) ? w_ext : 32'h0;
   assign o_sram_ce_n   = r_ce_n;
   assign o_sram_oe_n   = r_oe_n;
   assign o_sram_we_n   = r_we_n;
   assign o_sram_be_n   = r_be_n;
   assign o_sram_addr   = r_addr;
   assign o_sram_dq_out = r_dq;
   assign o_sram_dq_oe  = r_dq_oe;

   // request capture, beat sequencing and registered SRAM pins; SRAM data lanes advance NB bytes per beat
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_write <= 1'b0;
         r_null  <= 1'b0;
         r_f3    <= 3'b0;
         r_wc    <= 3'b0;
         r_off   <= 2'b0;
         r_pos   <= 2'b0;
         r_beat  <= 2'b0;
         r_last  <= 2'b0;
         r_wd    <= 32'h0;
         r_rd    <= 32'h0;
         r_bm    <= 4'h0;
         r_ce_n  <= 1'b1;
         r_oe_n  <= 1'b1;
         r_we_n  <= 1'b1;
         r_dq_oe <= 1'b0;
         r_be_n  <= '1;
         r_addr  <= '0;
         r_dq    <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
         r_mis   <= 1'b0;
`endif
      end else case (r_state)
         ST_IDLE: if (i_req_valid) begin
            r_write <= i_req_write;
            r_null  <= ~w_go;
            r_f3    <= i_req_funct3;
            r_off   <= w_off;
            r_pos   <= w_base;
            r_beat  <= 2'b0;
            r_last  <= 2'(beats(i_req_funct3, SRAM_DW) - 3'd1);
            r_wc    <= 3'b0;
            r_wd    <= w_wd;
            r_bm    <= w_bm;
            r_rd    <= 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_mis   <= w_mis & w_sup;
`endif
            r_state <= w_go ? ST_ACCESS : ST_DONE;
            if (w_go) begin
               r_ce_n  <= 1'b0;
               r_oe_n  <= i_req_write;
               r_we_n  <= ~i_req_write;
               r_dq_oe <= i_req_write;
               r_be_n  <= i_req_write ? w_be_nx : '0;
               r_addr  <= w_start;
               r_dq    <= i_req_write ? w_dq_nx : '0;
            end
         end
         ST_ACCESS: if (r_wc == 3'(WAIT_CYCLES)) begin
            r_wc <= 3'b0;
            if (!r_write) r_rd <= w_rd_nx;
            if (r_beat == r_last) begin
               r_state <= ST_DONE;
               r_ce_n  <= 1'b1;
               r_oe_n  <= 1'b1;
               r_we_n  <= 1'b1;
               r_dq_oe <= 1'b0;
               r_be_n  <= '1;
            end else begin
               r_beat <= r_beat + 2'd1;
               r_pos  <= w_pos_nx;
               r_addr <= r_addr + 1'b1;
               if (r_write) begin
                  r_dq   <= w_dq_nx;
                  r_be_n <= w_be_nx;
               end
            end
         end else r_wc <= r_wc + 3'd1;
         default: r_state <= ST_IDLE;
      endcase

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb_mem_stage_sram_ctrl: directed checks of the SRAM memory stage, DW=16/WAIT=1 and DW=8/WAIT=0 instances
module tb_mem_stage_sram_ctrl;
   import mem_pkg::*;

   logic clk = 1'b0, rst_n;
   always #5 clk = ~clk;

   // 16-bit, one wait state instance
   logic        req_valid, req_write, stall, rv, ce_n, oe_n, we_n, dq_oe, mis;
   logic [2:0]  req_f3;
   logic [31:0] req_addr, req_wdata, rdata;
   logic [1:0]  be_n;
   logic [19:0] saddr;
   logic [15:0] dq_out, dq_in;
   logic [15:0] mem16 [0:8191];

   // 8-bit, zero wait state instance
   logic        b_valid, b_write, b_stall, b_rv, b_ce_n, b_oe_n, b_we_n, b_dq_oe;
   logic [2:0]  b_f3;
   logic [31:0] b_addr, b_wdata, b_rdata;
   logic [0:0]  b_be_n;
   logic [19:0] b_saddr;
   logic [7:0]  b_dq_out, b_dq_in;
   logic [7:0]  mem8 [0:255];

   mem_stage_sram_ctrl #(.SRAM_DW(16), .SRAM_AW(20), .WAIT_CYCLES(1)) dut (
      .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid), .i_req_write(req_write),
      .i_req_funct3(req_f3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_stall(stall), .o_rdata_valid(rv), .o_rdata(rdata),
`ifdef MEM_MISALIGN_TRAP_EN
      .o_misaligned(mis),
`endif
      .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n), .o_sram_be_n(be_n),
      .o_sram_addr(saddr), .o_sram_dq_out(dq_out), .o_sram_dq_oe(dq_oe), .i_sram_dq_in(dq_in)
   );

   mem_stage_sram_ctrl #(.SRAM_DW(8), .SRAM_AW(20), .WAIT_CYCLES(0)) dut8 (
      .clk(clk), .rst_n(rst_n), .i_req_valid(b_valid), .i_req_write(b_write),
      .i_req_funct3(b_f3), .i_req_addr(b_addr), .i_req_wdata(b_wdata),
      .o_stall(b_stall), .o_rdata_valid(b_rv), .o_rdata(b_rdata),
`ifdef MEM_MISALIGN_TRAP_EN
      .o_misaligned(),
`endif
      .o_sram_ce_n(b_ce_n), .o_sram_oe_n(b_oe_n), .o_sram_we_n(b_we_n), .o_sram_be_n(b_be_n),
      .o_sram_addr(b_saddr), .o_sram_dq_out(b_dq_out), .o_sram_dq_oe(b_dq_oe), .i_sram_dq_in(b_dq_in)
   );

`ifndef MEM_MISALIGN_TRAP_EN
   assign mis = 1'b0;
`endif

   // SRAM models: combinational read while selected, lane-masked write on the clock
   assign dq_in   = (!ce_n && !oe_n) ? mem16[saddr[12:0]] : 16'h0;
   assign b_dq_in = (!b_ce_n && !b_oe_n) ? mem8[b_saddr[7:0]] : 8'h0;
   always @(posedge clk) begin
      if (!ce_n && !we_n && !be_n[0]) mem16[saddr[12:0]][7:0]  <= dq_out[7:0];
      if (!ce_n && !we_n && !be_n[1]) mem16[saddr[12:0]][15:8] <= dq_out[15:8];
      if (!b_ce_n && !b_we_n && !b_be_n[0]) mem8[b_saddr[7:0]] <= b_dq_out;
   end

   int n_chk = 0, n_fail = 0;
   int done_cyc, st_cnt, ce_cnt, we_cnt, oe_cnt;
   logic [31:0] got_rd;
   logic        got_mis;
   logic [19:0] tr_addr [0:39];
   logic [15:0] tr_dq   [0:39];
   logic [1:0]  tr_be   [0:39];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // drive one request on the 16-bit instance at a negedge and trace it until rdata_valid
   task automatic run16(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      req_valid = 1'b1; req_write = w; req_f3 = f3; req_addr = a; req_wdata = d;
      done_cyc = -1; st_cnt = 0; ce_cnt = 0; we_cnt = 0; oe_cnt = 0; got_rd = 32'h0; got_mis = 1'b0;
      for (int c = 0; c < 40 && done_cyc < 0; c++) begin
         #1;
         tr_addr[c] = saddr; tr_dq[c] = dq_out; tr_be[c] = be_n;
         st_cnt += int'(stall); ce_cnt += int'(!ce_n); we_cnt += int'(!we_n); oe_cnt += int'(dq_oe);
         if (rv) begin done_cyc = c; got_rd = rdata; got_mis = mis; end
         @(negedge clk);
      end
      req_valid = 1'b0;
   endtask

   task automatic run8(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      b_valid = 1'b1; b_write = w; b_f3 = f3; b_addr = a; b_wdata = d;
      done_cyc = -1; ce_cnt = 0; got_rd = 32'h0;
      for (int c = 0; c < 40 && done_cyc < 0; c++) begin
         #1;
         tr_addr[c] = b_saddr;
         ce_cnt += int'(!b_ce_n);
         if (b_rv) begin done_cyc = c; got_rd = b_rdata; end
         @(negedge clk);
      end
      b_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_f3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
      b_valid = 1'b0; b_write = 1'b0; b_f3 = 3'b0; b_addr = 32'h0; b_wdata = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_strobes", {28'h0, ce_n, oe_n, we_n, dq_oe}, 32'he);
      check("rst_be_n", 32'(be_n), 32'h3);
      check("rst_addr_dq", {saddr[15:0], dq_out}, 32'h0);
      check("rst_outputs", {rdata[29:0], stall, rv}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      run16(1'b1, F3_W, 32'h1000, 32'hDEADBEEF);
      check("s1_done_cycle", 32'(done_cyc), 5);
      check("s1_stall_cycles", 32'(st_cnt), 5);
      check("s1_beat1", {tr_addr[1][15:0], tr_dq[1]}, 32'h0800BEEF);
      check("s1_beat1_be", 32'(tr_be[1]), 0);
      check("s1_beat2", {tr_addr[3][15:0], tr_dq[3]}, 32'h0801DEAD);
      check("s1_we_oe_cycles", {32'(we_cnt)} << 8 | 32'(oe_cnt), 32'h404);
      check("s1_rdata", got_rd, 32'h0);
      check("s1_mem", {mem16[13'h801], mem16[13'h800]}, 32'hDEADBEEF);

      run16(1'b1, F3_H, 32'h1002, 32'h000080AA);
      check("s2_sh_mem", 32'(mem16[13'h801]), 32'h80AA);
      run16(1'b0, F3_B, 32'h1003, 32'h0);
      check("s2_lb", got_rd, 32'hFFFFFF80);
      check("s2_lb_addr_done", {tr_addr[1][15:0], 16'(done_cyc)}, 32'h08010003);
      run16(1'b0, F3_BU, 32'h1003, 32'h0);
      check("s2_lbu", got_rd, 32'h00000080);
      run16(1'b0, F3_H, 32'h1002, 32'h0);
      check("s2_lh", got_rd, 32'hFFFF80AA);

      run16(1'b1, F3_B, 32'h1001, 32'h12345678);
      check("s3_be_n", 32'(tr_be[1]), 32'h1);
      check("s3_dq_hi", 32'(tr_dq[1][15:8]), 32'h78);
      check("s3_we_cycles", 32'(we_cnt), 2);
      check("s3_mem", 32'(mem16[13'h800]), 32'h78EF);

      run16(1'b0, F3_W, 32'h1002, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
      check("s4_done_cycle", 32'(done_cyc), 1);
      check("s4_misaligned", 32'(got_mis), 1);
      check("s4_ce_cycles", 32'(ce_cnt), 0);
      check("s4_rdata", got_rd, 32'h0);
`else
      check("s4_done_cycle", 32'(done_cyc), 5);
      check("s4_addrs", {tr_addr[1][15:0], tr_addr[3][15:0]}, 32'h08000801);
      check("s4_rdata", got_rd, 32'h80AA78EF);
      check("s4_misaligned", 32'(got_mis), 0);
`endif

      run16(1'b0, 3'b011, 32'h1000, 32'h0);
      check("unsup_done_stall", {16'(done_cyc), 16'(st_cnt)}, 32'h00010001);
      check("unsup_ce_rdata", got_rd | 32'(ce_cnt), 32'h0);

      run16(1'b1, F3_W, 32'h2000, 32'h12345678);
      req_valid = 1'b1; req_write = 1'b1; req_f3 = F3_W; req_addr = 32'h1000; req_wdata = 32'hCAFEF00D;
      repeat (3) @(negedge clk);
      #1;
      check("s5_second_beat", {tr_addr[0][15:12], 11'h0, ce_n, saddr[15:0]}, {tr_addr[0][15:12], 11'h0, 1'b0, 16'h0801});
      rst_n = 1'b0;
      #1;
      check("s5_rst_strobes", {28'h0, ce_n, oe_n, we_n, dq_oe}, 32'he);
      check("s5_rst_be_stall", {29'h0, be_n, stall}, 32'h6);
      req_valid = 1'b0;
      @(negedge clk);
      #1;
      check("s5_rst_addr_dq", {saddr[15:0], dq_out}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      run16(1'b0, F3_W, 32'h2000, 32'h0);
      check("s5_lw_after_rst", got_rd, 32'h12345678);
      check("s5_lw_done_addr", {16'(done_cyc), tr_addr[1][15:0]}, 32'h00051000);

      run8(1'b1, F3_W, 32'h0004, 32'h44332211);
      check("s6_store_mem", {mem8[7], mem8[6], mem8[5], mem8[4]}, 32'h44332211);
      run8(1'b0, F3_W, 32'h0004, 32'h0);
      check("s6_rdata", got_rd, 32'h44332211);
      check("s6_done_cycle", 32'(done_cyc), 5);
      check("s6_beat_addrs", {tr_addr[1][7:0], tr_addr[2][7:0], tr_addr[3][7:0], tr_addr[4][7:0]}, 32'h04050607);
      check("s6_ce_cycles", 32'(ce_cnt), 4);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
